// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage SRAM engine states and memory map constants.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam logic [31:0] BASE_ADDR = 32'd1024;
  localparam int          SRAM_AW   = 18;
  localparam int          DATA_W    = 32;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory engine: splits each 32-bit load/store into two 16-bit
// accesses on an external asynchronous SRAM, low half first.
module mem_stage_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = mips_pkg::BASE_ADDR,
  parameter int          HALF_CYCLES = 3,
  parameter int          SRAM_AW     = mips_pkg::SRAM_AW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_en,
  input  logic                        wr_en,
  input  logic [mips_pkg::DATA_W-1:0] address,
  input  logic [mips_pkg::DATA_W-1:0] write_data,
  output logic [mips_pkg::DATA_W-1:0] read_data,
  output logic                        ready,
  output logic [SRAM_AW-1:0]          SRAM_ADDR,
  inout  wire  [15:0]                 SRAM_DQ,
  output logic                        SRAM_WE_N,
  output logic                        SRAM_CE_N,
  output logic                        SRAM_OE_N,
  output logic                        SRAM_UB_N,
  output logic                        SRAM_LB_N
);

  import mips_pkg::*;

  localparam int              CNT_W  = $clog2(HALF_CYCLES + 1);
  localparam int              WORD_W = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(HALF_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  word_q;
  logic [31:0]        data_q;
  logic               write_q;
  logic [15:0]        rd_lo;
  logic               req, active, phase_end, drive;

  assign req       = rd_en | wr_en;
  assign active    = (state == LOW) || (state == HIGH);
  assign phase_end = active && (cnt == LAST);
  assign drive     = write_q && active;

  // NOTE: every register uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = LOW;
      end
      LOW:  if (phase_end) state_nxt = HIGH;
      HIGH: if (phase_end) state_nxt = DONE;
      DONE: begin
        // The pipeline advances on this edge, so requests are not looked at here.
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      word_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      rd_lo     <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        // Only the word index survives; byte offset and out-of-range bits alias away.
        word_q  <= WORD_W'((address - BASE_ADDR) >> 2);
        data_q  <= write_data;
        write_q <= wr_en;
        cnt     <= '0;
      end else if (active) begin
        cnt <= phase_end ? '0 : cnt + 1'b1;
      end

      // Loaded word is assembled on the final HIGH edge so it is valid throughout DONE.
      if (phase_end && !write_q) begin
        if (state == LOW) rd_lo     <= SRAM_DQ;
        else              read_data <= {SRAM_DQ, rd_lo};
      end
    end
  end

  assign SRAM_ADDR = {word_q, state == HIGH};
  assign SRAM_WE_N = ~drive;
  assign SRAM_DQ   = drive ? ((state == HIGH) ? data_q[31:16] : data_q[15:0]) : 16'hzzzz;

  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: three instances (HALF_CYCLES 3, 1, 4), each on a
// behavioural SRAM, checked against a word-level reference memory.
module tb_mem_stage_sram_ctrl;
  import mips_pkg::*;

  localparam int N  = 3;
  localparam int AW = SRAM_AW;

  function automatic int hc_of(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 1 : 4);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rd_en      [N];
  logic          wr_en      [N];
  logic [31:0]   address    [N];
  logic [31:0]   write_data [N];
  logic [31:0]   read_data  [N];
  logic          ready      [N];
  logic [AW-1:0] sram_addr  [N];
  logic          we_n       [N];
  logic          ce_n       [N];
  logic          oe_n       [N];
  logic          ub_n       [N];
  logic          lb_n       [N];
  wire  [15:0]   dq_obs     [N];
  wire  [15:0]   mem_rd     [N];

  for (genvar g = 0; g < N; g++) begin : gen_u
    wire  [15:0] dq;
    logic [15:0] mem [2**AW];

    // Async SRAM with OE tied low: drives the bus whenever not being written.
    assign mem_rd[g] = mem[sram_addr[g]];
    assign dq        = we_n[g] ? mem[sram_addr[g]] : 16'hzzzz;
    assign dq_obs[g] = dq;
    always @(negedge clk) if (we_n[g] == 1'b0) mem[sram_addr[g]] <= dq;

    mem_stage_sram_ctrl #(
      .BASE_ADDR  (BASE_ADDR),
      .HALF_CYCLES(hc_of(g)),
      .SRAM_AW    (AW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en[g]),
      .wr_en     (wr_en[g]),
      .address   (address[g]),
      .write_data(write_data[g]),
      .read_data (read_data[g]),
      .ready     (ready[g]),
      .SRAM_ADDR (sram_addr[g]),
      .SRAM_DQ   (dq),
      .SRAM_WE_N (we_n[g]),
      .SRAM_CE_N (ce_n[g]),
      .SRAM_OE_N (oe_n[g]),
      .SRAM_UB_N (ub_n[g]),
      .SRAM_LB_N (lb_n[g])
    );
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd  [N];

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 2;
    return int'(off % (32'd1 << (AW - 1)));
  endfunction

  function automatic int key_of(input int u, input logic [31:0] a);
    return u * (1 << 20) + widx(a);
  endfunction

  // One full access; called just after a rising edge with the instance idle,
  // returns just after the DONE->IDLE edge so the next call is back-to-back.
  task automatic access(input int u, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d, input string name);
    int          lat, h, w, half;
    bit          wave_ok;
    logic [31:0] got;
    logic [AW-1:0] ea;
    h = hc_of(u);
    w = widx(a);
    wave_ok = 1'b1;
    rd_en[u] = rd; wr_en[u] = wr; address[u] = a; write_data[u] = d;
    for (lat = 0; lat < 64; lat++) begin
      @(negedge clk);
      if (ready[u]) break;
      if (lat >= 1) begin
        half = (lat - 1) / h;
        ea   = AW'(w * 2 + half);
        if (half > 1 || sram_addr[u] !== ea) wave_ok = 1'b0;
        if (wr) begin
          if (we_n[u] !== 1'b0 || dq_obs[u] !== ((half != 0) ? d[31:16] : d[15:0])) wave_ok = 1'b0;
        end else begin
          if (we_n[u] !== 1'b1 || dq_obs[u] !== mem_rd[u]) wave_ok = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    got = read_data[u];

    if (wr) ref_mem[key_of(u, a)] = d;
    else if (ref_mem.exists(key_of(u, a))) exp_rd[u] = ref_mem[key_of(u, a)];

    n_checks++;
    if (lat != 2 * h + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, 2 * h + 1);
    end
    n_checks++;
    if (!wave_ok) begin
      n_fail++;
      $display("FAIL %s sram_waveform: address/we_n/dq sequence wrong (addr=%h rd=%0b wr=%0b)", name, a, rd, wr);
    end
    n_checks++;
    if (got !== exp_rd[u]) begin
      n_fail++;
      $display("FAIL %s read_data: got %h, want %h", name, got, exp_rd[u]);
    end
    @(posedge clk); #1;
    rd_en[u] = 1'b0; wr_en[u] = 1'b0;
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (ready[0] !== 1'b1 || we_n[0] !== 1'b1 || dq_obs[0] !== mem_rd[0]) begin
      n_fail++;
      $display("FAIL %s idle_bus: ready=%b we_n=%b dq=%h (sram %h), want ready=1 we_n=1 undriven",
               name, ready[0], we_n[0], dq_obs[0], mem_rd[0]);
    end
    n_checks++;
    if (read_data[0] !== exp_rd[0]) begin
      n_fail++;
      $display("FAIL %s read_data: got %h, want %h", name, read_data[0], exp_rd[0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < N; u++) begin
      rd_en[u] = 1'b0; wr_en[u] = 1'b0; address[u] = '0; write_data[u] = '0; exp_rd[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    n_checks++;
    if (sram_addr[0] !== '0) begin
      n_fail++;
      $display("FAIL reset sram_addr: got %h, want 0", sram_addr[0]);
    end
    n_checks++;
    if ({ce_n[0], oe_n[0], ub_n[0], lb_n[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset tie_offs: got %b, want 0000", {ce_n[0], oe_n[0], ub_n[0], lb_n[0]});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_trip();
    access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, "rt_store");
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0, "rt_load");
    n_checks++;
    if (exp_rd[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rt_model: got %h, want deadbeef", exp_rd[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    v = $urandom;
    access(0, 1'b0, 1'b1, 32'd1032, v, "b2b_store");
    access(0, 1'b1, 1'b0, 32'd1032, 32'h0, "b2b_load");
  endtask

  task automatic test_simultaneous();
    access(0, 1'b1, 1'b1, 32'd1036, 32'h12345678, "both_store");
    access(0, 1'b1, 1'b0, 32'd1036, 32'h0, "both_load");
  endtask

  task automatic test_reset_mid();
    rd_en[0] = 1'b0; wr_en[0] = 1'b1;
    address[0] = BASE_ADDR + 32'd1024; write_data[0] = 32'hCAFEF00D;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (we_n[0] !== 1'b0 || sram_addr[0] !== AW'(2 * widx(address[0]) + 1)) begin
      n_fail++;
      $display("FAIL mid_high_phase: we_n=%b addr=%h, want 0 and %h", we_n[0], sram_addr[0],
               AW'(2 * widx(address[0]) + 1));
    end
    #1 rst = 1'b1;
    wr_en[0] = 1'b0;
    for (int u = 0; u < N; u++) exp_rd[u] = '0;
    #1;
    check_idle("mid_reset");
    n_checks++;
    if (sram_addr[0] !== '0) begin
      n_fail++;
      $display("FAIL mid_reset sram_addr: got %h, want 0", sram_addr[0]);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b0, 1'b1, 32'd1040, 32'h0BADC0DE, "post_reset_store");
    access(0, 1'b1, 1'b0, 32'd1040, 32'h0, "post_reset_load");
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    int          op;
    for (int i = 0; i < 24; i++) begin
      a  = BASE_ADDR + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = a + 32'h0008_0000;
      d  = $urandom;
      op = $urandom_range(0, 2);
      if (op == 2 && !ref_mem.exists(key_of(0, a))) op = 0;
      case (op)
        0:       access(0, 1'b0, 1'b1, a, d, "rand_store");
        1:       access(0, 1'b1, 1'b1, a, d, "rand_both");
        default: access(0, 1'b1, 1'b0, a, d, "rand_load");
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_idle("rand_gap");
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_latency_sweep();
    for (int u = 1; u < N; u++) begin
      access(u, 1'b0, 1'b1, BASE_ADDR + 32'd16, $urandom, "sweep_store");
      access(u, 1'b1, 1'b0, BASE_ADDR + 32'd16, 32'h0, "sweep_load");
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Data-memory access engine for the MEM stage of the 5-stage MIPS pipeline.
- Converts one 32-bit load or store from the EX/MEM side into two 16-bit accesses on an external asynchronous SRAM.
- Produces the 32-bit read value that feeds the MEM/WB pipeline register.
- Asserts ready only when the access is complete; the hazard logic freezes the pipeline while a request is pending and ready is low.

Parameters:
- BASE_ADDR, 32'd1024: byte address mapped to SRAM location 0.
- HALF_CYCLES, 3: clock cycles per 16-bit half access. Legal range is 1 or more.
- SRAM_AW, 18: SRAM address width in 16-bit words.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  load request (MEM_R_EN from EX/MEM).
- wr_en  input  1  store request (MEM_W_EN from EX/MEM).
- address  input  32  byte address (ALU result).
- write_data  input  32  store data.
- read_data  output  32  loaded word, registered.
- ready  output  1  high when no access is pending or the current access completes this cycle.
- SRAM_ADDR  output  SRAM_AW  SRAM word address.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_WE_N  output  1  active-low write enable.
- SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied to 0.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. Cycle counter width is $clog2(HALF_CYCLES+1).
- Reset is asynchronous and takes effect immediately, even mid-access:
  - state goes to IDLE, counter to 0, read_data to 0.
  - SRAM_ADDR goes to 0 and SRAM_WE_N to 1.
  - SRAM_DQ is released to high-Z and internal latches are cleared.
- IDLE:
  - ready = ~(rd_en | wr_en).
  - On a request, latch address, write_data and op, then go to LOW with counter 0.
  - If rd_en and wr_en are both high, the access is a write.
- Address mapping:
  - off = address - BASE_ADDR, modulo 2^32.
  - SRAM_ADDR = {off[SRAM_AW:2], half}, where half is 0 in LOW and 1 in HIGH.
  - off[1:0] is ignored; only word accesses are supported.
  - Addresses outside the SRAM range alias silently; no error is raised.
- LOW and HIGH phases:
  - Each lasts exactly HALF_CYCLES cycles, with the counter running 0..HALF_CYCLES-1.
  - SRAM_ADDR is stable for the whole phase.
  - Write: SRAM_WE_N = 0 and SRAM_DQ is driven for the whole phase. LOW drives latched data[15:0]; HIGH drives data[31:16].
  - Read: SRAM_WE_N = 1 and SRAM_DQ is high-Z. SRAM_DQ is sampled on the last cycle of the phase, into rd_lo in LOW and rd_hi in HIGH.
  - LOW goes to HIGH, and HIGH goes to DONE, on the last cycle of the phase.
- DONE (exactly 1 cycle):
  - ready = 1, SRAM_WE_N = 1, SRAM_DQ is high-Z.
  - For a read, read_data = {rd_hi, rd_lo} is visible in this cycle. rd_hi must be captured so that read_data is valid during DONE.
  - Next state is always IDLE. Request inputs are ignored in DONE, because the pipeline advances on this edge.
- Latency: request first seen in IDLE at cycle 0 gives ready = 1 at cycle 2*HALF_CYCLES+1 (7 with defaults).
- ready is low in LOW and HIGH.
- read_data holds its value across writes and idle cycles; it updates only at the completion of a read.
- A request arriving in the cycle immediately after DONE is accepted from IDLE normally, so back-to-back accesses have no bubble beyond DONE.
- The block never drives SRAM_DQ outside a write phase (no bus contention).

Decomposition:
- Shared package mips_pkg holds:
  - the state enum {IDLE, LOW, HIGH, DONE};
  - the constants BASE_ADDR and SRAM_AW;
  - the localparam DATA_W = 32.
- No sub-module. The tri-state driver is a single continuous assignment inside this block.
- The bench supplies a behavioural 2^SRAM_AW x 16 SRAM model.

Test Plan:
- Reset, then idle: with rst held and released, both requests low -> ready = 1, SRAM_WE_N = 1, SRAM_DQ = Z, read_data = 0.
- Store then load round trip: wr_en with address = 1028 and write_data = 32'hDEADBEEF.
  - Requirements: SRAM_ADDR = 2 with DQ = BEEF for 3 cycles, then SRAM_ADDR = 3 with DQ = DEAD for 3 cycles; ready high at cycle 7.
  - Follow-up: rd_en at 1028 -> read_data = 32'hDEADBEEF in the DONE cycle.
- Back-to-back: a write to 1032 immediately followed by a read of 1032 -> second request accepted in the cycle after DONE; read returns the written value; no bus contention.
- Simultaneous rd_en and wr_en at 1036 with data 32'h12345678 -> performed as a write; a later read of 1036 returns 32'h12345678; read_data unchanged by the write.
- Reset mid-access: rst asserted during the HIGH phase of a write -> SRAM_WE_N = 1 and DQ = Z in the same cycle; state IDLE; next request starts cleanly.
- Latency sweep: HALF_CYCLES = 1 and 4 -> ready at cycle 3 and cycle 9 respectively.
